// File: rtl/arb_requester.sv
// arb_requester: per-channel job queue, request driver and fixed-length burst engine for a 4-way arbiter.
// Define ARB_REQ_TIMEOUT_EN to add the starvation watchdog and its timeout port.
module arb_requester #(
    parameter int DEPTH          = 3,
    parameter int BURST_LEN      = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] push,
    output logic [3:0] push_ready,
    output logic [3:0] out_request,
    input  logic [3:0] in_grant,
    output logic       xfer_valid,
    output logic [1:0] xfer_chan,
    output logic       xfer_last,
    output logic       grant_err
`ifdef ARB_REQ_TIMEOUT_EN
    ,
    output logic       timeout
`endif
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;

    if (DEPTH < 1 || DEPTH > 15 || BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("arb_requester: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;
    state_t        state, state_nxt;
    logic [1:0]    owner;
    logic [BW-1:0] beat;
    logic [PW-1:0] pending [4];
    logic [3:0]    inc, dec, req_nxt;
    logic          grant_match, grant_ok, grant_bad, last;

    assign grant_match = $onehot(in_grant) && |(in_grant & out_request);
    assign grant_ok    = state == IDLE && grant_match;
    assign grant_bad   = state == IDLE && |in_grant && !grant_match;
    assign last        = beat == BW'(BURST_LEN - 1);
    assign inc         = push & push_ready;
    assign dec         = (state == XFER && last) ? 4'b0001 << owner : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE ? (grant_ok ? XFER : IDLE)
                  : state == XFER ? (last ? RELEASE : XFER)
                  : IDLE;
    end

    always_comb begin
        xfer_valid = state == XFER;
        xfer_chan  = xfer_valid ? owner : 2'd0;
        xfer_last  = xfer_valid && last;
    end

    // Request follows the registered count; the owner's bit drops for the RELEASE cycle.
    always_comb begin
        req_nxt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            push_ready[i] = pending[i] < PW'(DEPTH);
            req_nxt[i]    = pending[i] != '0 && !(state_nxt == RELEASE && owner == 2'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= 2'd0;
            beat        <= '0;
            grant_err   <= 1'b0;
            out_request <= 4'b0000;
            for (int i = 0; i < 4; i++) pending[i] <= '0;
        end else begin
            if (grant_ok) begin
                owner <= {in_grant[3] | in_grant[2], in_grant[3] | in_grant[1]};
                beat  <= '0;
            end else if (state == XFER) begin
                beat <= beat + BW'(1);
            end
            if (grant_bad) grant_err <= 1'b1;
            out_request <= req_nxt;
            for (int i = 0; i < 4; i++) pending[i] <= pending[i] + PW'(inc[i]) - PW'(dec[i]);
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          starving;

    assign starving = state == IDLE && |out_request && !grant_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (grant_ok) begin
                tcnt <= '0;
            end else if (starving) begin
                tcnt    <= tcnt == TW'(TIMEOUT_CYCLES - 1) ? '0 : tcnt + TW'(1);
                timeout <= tcnt == TW'(TIMEOUT_CYCLES - 1);
            end
        end
    end
`endif
endmodule

// File: doc/arb_requester.md
# arb_requester

Requester-side front end for the 4-way priority arbiter. Queues jobs per channel, drives the arbiter's 4-bit request vector, and accepts the arbiter's one-hot grant. On a valid grant it runs a fixed-length transfer burst for the winning channel, then releases that channel's request for one cycle so the arbiter can re-arbitrate. Sits between the channel job sources and the arbiter's `in_request`/`out_grant` pins.

## Interface
- `DEPTH`, 3: maximum pending jobs per channel (1–15)
- `BURST_LEN`, 4: beats per granted transfer (1–16)
- `TIMEOUT_CYCLES`, 32: starvation watchdog limit; used only with the macro enabled
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `push` in 4: per-channel job enqueue strobe, sampled at posedge
- `push_ready` out 4: channel i accepts a push (pending[i] < DEPTH)
- `out_request` out 4: registered request vector to the arbiter's `in_request`
- `in_grant` in 4: grant vector from the arbiter's `out_grant`
- `xfer_valid` out 1: transfer beat active
- `xfer_chan` out 2: channel owning the current beat
- `xfer_last` out 1: final beat of the burst
- `grant_err` out 1: sticky illegal-grant flag
- `timeout` out 1: one-cycle starvation pulse; present only with `ARB_REQ_TIMEOUT_EN`

## Operation
- Per-channel pending counter, width clog2(DEPTH+1).
  - `push[i]` while `push_ready[i]` increments the counter.
  - `push[i]` while full is dropped; the counter holds.
- FSM states: IDLE, XFER, RELEASE.
- **IDLE**
  - `in_grant` one-hot, matching a set bit in `out_request`: latch that channel as owner, clear the beat counter, go to XFER.
  - `in_grant` zero: stay in IDLE.
  - `in_grant` multi-hot, or one-hot on a channel whose `out_request` bit is low: set `grant_err`, stay in IDLE, start no transfer.
- **XFER**
  - Every cycle: `xfer_valid`=1, `xfer_chan`=owner.
  - Beat counter counts 0..BURST_LEN-1.
  - `xfer_last`=1 on beat BURST_LEN-1.
  - After the last beat: decrement pending[owner], go to RELEASE.
  - `in_grant` is ignored in this state, including changes and multi-hot values.
- **RELEASE**
  - Lasts one cycle.
  - `out_request[owner]` is forced low; the other request bits are unaffected.
  - Return to IDLE.
- `out_request[i]` register next value = (pending[i] != 0) and not (next state is RELEASE and owner == i).
- Push to the owner channel on its completion cycle: the increment and decrement cancel, and the count is unchanged.
- `grant_err` clears only on reset.

## Timing
- Reset values: FSM=IDLE, all pending=0, `out_request`=0, `push_ready`=4'b1111, `xfer_valid`=0, `xfer_chan`=0, `xfer_last`=0, `grant_err`=0, `timeout`=0.
- Push to request: a push at edge N makes `out_request[i]` high after edge N+1.
- Grant to first beat: a valid grant sampled at edge G gives `xfer_valid` high from edge G+1.
- Burst: beats are high for edges G+1..G+BURST_LEN. RELEASE is the cycle after G+BURST_LEN.
- The request re-asserts one cycle after RELEASE if pending is still nonzero.
- `push_ready` follows the pending counter with the same-edge update.
- Asserting `rst` mid-burst ends the burst immediately, clears all pending counts, and returns every output to its reset value.

## Configuration
- `ARB_REQ_TIMEOUT_EN` defined:
  - A counter runs while `out_request` is nonzero and the FSM is in IDLE without accepting a grant.
  - When the counter reaches TIMEOUT_CYCLES, `timeout` pulses high for one cycle and the counter restarts.
  - The counter clears on any grant acceptance and on reset.
- `ARB_REQ_TIMEOUT_EN` undefined: no counter and no `timeout` port. All other behaviour is identical.

## Test plan
- **Reset, single job:** reset, then push=4'b0001 for one cycle.
  - `out_request`=4'b0001.
  - Grant 4'b0001 gives 4 beats with `xfer_chan`=0 and `xfer_last` on beat 4.
  - RELEASE follows with `out_request`=0.
- **Fill and overflow:** push channel 2 four times with DEPTH=3.
  - `push_ready[2]` goes low after the third push; the fourth is dropped.
  - Three grants complete three bursts, then `out_request[2]` stays 0.
- **Competing requests:** push channels 0, 1, 2; arbiter grants 4'b0001, then 4'b0010, then 4'b0100.
  - Three back-to-back bursts, each followed by RELEASE with only the owner's request bit low.
- **Illegal grants:** `in_grant`=4'b1000 with `out_request`=4'b0001, then `in_grant`=4'b0011.
  - `grant_err`=1, no `xfer_valid`, FSM stays in IDLE.
- **Reset mid-burst:** `rst` asserted on beat 2.
  - `xfer_valid`=0, `out_request`=0 and `push_ready`=4'b1111 immediately (asynchronously).
- **Starvation (macro enabled), TIMEOUT_CYCLES=32:** request held with `in_grant`=0 for 32 cycles.
  - `timeout` pulses once; a later grant clears the counter.
